// File: rtl/prog3.sv
// rtl/prog3.sv - 4-bit pattern occurrence counter over a 64-bit string
//
// Counts how many 4-bit windows of str equal pat and registers three counts.
// Ports:
//   clk    in   1  rising-edge clock
//   reset  in   1  synchronous active-high clear of all outputs
//   pat    in   4  pattern to search for
//   str    in  64  string searched; byte 0 is the MSB byte
//   ctb    out  8  matches lying wholly inside one byte
//   cts    out  8  matches anywhere in the string
//   cto    out  8  bytes holding at least one in-byte match
module prog3 (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  pat,
    input  logic [63:0] str,
    output logic [7:0]  ctb,
    output logic [7:0]  cts,
    output logic [7:0]  cto
);

    // match[j] is set when str[j+3:j] equals pat, j = 0..60.
    logic [60:0] match;
    // in_byte marks windows whose four bits sit inside a single byte.
    logic [60:0] in_byte;
    // byte_hit[b] covers bits [8b+7:8b]; the byte numbering order does not
    // matter here because only the number of hit bytes is reported.
    logic [7:0]  byte_hit;

    logic [7:0]  n_ctb;
    logic [7:0]  n_cts;
    logic [7:0]  n_cto;

    always_comb begin
        match   = '0;
        in_byte = '0;
        for (int j = 0; j < 61; j++) begin
            match[j]   = (str[j +: 4] == pat);
            in_byte[j] = ((j % 8) <= 4);
        end
    end

    always_comb begin
        byte_hit = '0;
        for (int b = 0; b < 8; b++) begin
            // Only the five windows starting at offsets 0..4 stay inside
            // the byte; boundary-spanning matches never mark a byte.
            byte_hit[b] = |match[8*b +: 5];
        end
    end

    always_comb begin
        n_ctb = '0;
        n_cts = '0;
        n_cto = '0;
        for (int j = 0; j < 61; j++) begin
            if (match[j]) begin
                n_cts = n_cts + 8'd1;
                if (in_byte[j]) begin
                    n_ctb = n_ctb + 8'd1;
                end
            end
        end
        for (int b = 0; b < 8; b++) begin
            if (byte_hit[b]) begin
                n_cto = n_cto + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctb <= 8'd0;
            cts <= 8'd0;
            cto <= 8'd0;
        end else begin
            ctb <= n_ctb;
            cts <= n_cts;
            cto <= n_cto;
        end
    end

endmodule

// File: tb/tb_prog3.sv
// tb/tb_prog3.sv - directed self-checking bench for prog3
module tb_prog3;

    logic        clk;
    logic        reset;
    logic [3:0]  pat;
    logic [63:0] str;
    logic [7:0]  ctb;
    logic [7:0]  cts;
    logic [7:0]  cto;

    int checks;
    int errors;

    prog3 dut (
        .clk   (clk),
        .reset (reset),
        .pat   (pat),
        .str   (str),
        .ctb   (ctb),
        .cts   (cts),
        .cto   (cto)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  pat;
        logic [63:0] str;
        logic [7:0]  ctb;
        logic [7:0]  cts;
        logic [7:0]  cto;
    } vec_t;

    vec_t vecs[16];
    int   nvec;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check3(input string name, input logic [7:0] e_ctb,
                          input logic [7:0] e_cts, input logic [7:0] e_cto);
        check({name, ".ctb"}, ctb, e_ctb);
        check({name, ".cts"}, cts, e_cts);
        check({name, ".cto"}, cto, e_cto);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check3("reset", 8'd0, 8'd0, 8'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic apply(input logic [3:0] p, input logic [63:0] s);
        @(negedge clk);
        pat = p;
        str = s;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input string n, input logic [3:0] p, input logic [63:0] s,
                       input logic [7:0] b, input logic [7:0] t, input logic [7:0] o);
        vecs[nvec].name = n;
        vecs[nvec].pat  = p;
        vecs[nvec].str  = s;
        vecs[nvec].ctb  = b;
        vecs[nvec].cts  = t;
        vecs[nvec].cto  = o;
        nvec++;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        nvec   = 0;
        reset  = 1'b0;
        pat    = 4'd0;
        str    = 64'd0;

        // Accumulating steps with pat=1011.
        add("step1",   4'b1011, 64'h0000_0000_0000_0000, 8'd0,  8'd0,  8'd0);
        add("step2",   4'b1011, 64'h0000_0000_0000_B000, 8'd1,  8'd1,  8'd1);
        add("step3",   4'b1011, 64'h0000_0000_00BB_B000, 8'd3,  8'd3,  8'd2);
        add("step4",   4'b1011, 64'h0000_02C0_00BB_B000, 8'd3,  8'd4,  8'd2);
        add("step5",   4'b1011, 64'hBB00_02C0_00BB_B000, 8'd5,  8'd6,  8'd3);
        // Edge cases and extra patterns.
        add("ff_top",  4'b1111, 64'hFF00_0000_0000_0000, 8'd5,  8'd5,  8'd1);
        add("zero_0",  4'b0000, 64'h0000_0000_0000_0000, 8'd40, 8'd61, 8'd8);
        add("ones_1",  4'b1111, 64'hFFFF_FFFF_FFFF_FFFF, 8'd40, 8'd61, 8'd8);
        add("zero_1s", 4'b0000, 64'hFFFF_FFFF_FFFF_FFFF, 8'd0,  8'd0,  8'd0);
        add("lsb",     4'b0001, 64'h0000_0000_0000_0001, 8'd1,  8'd1,  8'd1);
        add("hi_nib",  4'b1000, 64'h0000_0000_0000_0080, 8'd1,  8'd1,  8'd1);
        add("span",    4'b1000, 64'h0000_0000_0000_0100, 8'd0,  8'd1,  8'd0);
        add("alt",     4'b0000, 64'h00FF_00FF_00FF_00FF, 8'd20, 8'd20, 8'd4);

        for (int i = 0; i < nvec; i++) begin
            do_reset();
            apply(vecs[i].pat, vecs[i].str);
            check3(vecs[i].name, vecs[i].ctb, vecs[i].cts, vecs[i].cto);
            // Holding inputs another cycle must give the same result.
            apply(vecs[i].pat, vecs[i].str);
            check3({vecs[i].name, "_hold"}, vecs[i].ctb, vecs[i].cts, vecs[i].cto);
        end

        // Latency: new inputs between edges must not reach the outputs early.
        apply(4'b1011, 64'hBB00_02C0_00BB_B000);
        check3("pre", 8'd5, 8'd6, 8'd3);
        @(negedge clk);
        pat = 4'b0000;
        str = 64'd0;
        #2;
        check3("no_early", 8'd5, 8'd6, 8'd3);
        @(posedge clk);
        #1;
        check3("after_edge", 8'd40, 8'd61, 8'd8);

        // Reset mid-stream with step-5 inputs held.
        apply(4'b1011, 64'hBB00_02C0_00BB_B000);
        check3("mid_pre", 8'd5, 8'd6, 8'd3);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check3("mid_reset", 8'd0, 8'd0, 8'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check3("mid_resume", 8'd5, 8'd6, 8'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
